// File: rtl/simon_pkg.sv
// Shared definitions for the Simon game: colour encoding, sequence sizing
// and the playback state set used by the player, capture state and top FSM.
package simon_pkg;

  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] GREEN  = 2'b01;
  localparam logic [1:0] BLUE   = 2'b10;
  localparam logic [1:0] YELLOW = 2'b11;

  localparam int SEQ_W = 32;
  localparam int LEN_W = 4;

  typedef enum logic [1:0] {
    PS_IDLE = 2'd0,
    PS_ON   = 2'd1,
    PS_OFF  = 2'd2,
    PS_DONE = 2'd3
  } player_state_e;

  // Colour i sits at bits [2i+1:2i]; index 15 would read past the 15 usable slots
  // but sequence_len caps the index at 14.
  function automatic logic [1:0] colour_at(input logic [SEQ_W-1:0] seq,
                                           input logic [LEN_W-1:0] idx);
    return seq[{idx, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that saturates at zero; tc is high while the count is zero.
module phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == '0);

endmodule

// File: rtl/sequence_player.sv
// Replays a latched packed colour sequence one colour at a time with a fixed
// on-time per colour and a fixed blank gap between colours.
module sequence_player
  import simon_pkg::*;
#(
  parameter int unsigned ON_CYCLES  = 4,
  parameter int unsigned OFF_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] sequence_val,
  input  logic [3:0]  sequence_len,
  output logic [1:0]  colour_out,
  output logic        colour_valid,
  output logic [3:0]  play_index,
  output logic        complete_play
);

  localparam logic [1:0] ST_IDLE = 2'(PS_IDLE);
  localparam logic [1:0] ST_ON   = 2'(PS_ON);
  localparam logic [1:0] ST_OFF  = 2'(PS_OFF);
  localparam logic [1:0] ST_DONE = 2'(PS_DONE);

  localparam int unsigned MAX_ONOFF = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int unsigned MAX_CYC   = (MAX_ONOFF > 2) ? MAX_ONOFF : 2;
  localparam int          TMR_W     = $clog2(MAX_CYC);

  // Timer holds "cycles remaining after this one", so a phase of N cycles loads N-1.
  localparam logic [TMR_W-1:0] ON_LOAD  = TMR_W'(ON_CYCLES - 1);
  localparam logic [TMR_W-1:0] OFF_LOAD = (OFF_CYCLES == 0) ? '0 : TMR_W'(OFF_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [1:0]       colour_out_q, colour_out_d;
  logic             colour_valid_q, colour_valid_d;
  logic [LEN_W-1:0] play_index_q, play_index_d;
  logic             complete_play_q, complete_play_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             en_low_q, en_low_d;

  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_tc;
  logic             last_colour;

  phase_timer #(
    .W(TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  assign last_colour = (play_index_q == (len_q - LEN_W'(1)));

  always_comb begin
    state_d         = state_q;
    colour_out_d    = colour_out_q;
    colour_valid_d  = colour_valid_q;
    play_index_d    = play_index_q;
    complete_play_d = complete_play_q;
    seq_d           = seq_q;
    len_d           = len_q;
    tmr_load        = 1'b0;
    tmr_val         = ON_LOAD;
    // A start needs en to have been low on the previous edge, which also
    // blocks a replay straight after reset or DONE while en stays high.
    en_low_d        = ~en;

    case (state_q)
      ST_IDLE: begin
        colour_out_d    = 2'b00;
        colour_valid_d  = 1'b0;
        play_index_d    = '0;
        complete_play_d = 1'b0;
        if (en && en_low_q) begin
          seq_d = sequence_val;
          len_d = sequence_len;
          if (sequence_len != '0) begin
            state_d        = ST_ON;
            colour_valid_d = 1'b1;
            colour_out_d   = colour_at(sequence_val, '0);
            tmr_load       = 1'b1;
            tmr_val        = ON_LOAD;
          end else begin
            state_d         = ST_DONE;
            complete_play_d = 1'b1;
          end
        end
      end

      ST_ON: begin
        if (!en) begin
          state_d        = ST_IDLE;
          colour_out_d   = 2'b00;
          colour_valid_d = 1'b0;
          play_index_d   = '0;
        end else if (tmr_tc) begin
          if (last_colour) begin
            state_d         = ST_DONE;
            colour_out_d    = 2'b00;
            colour_valid_d  = 1'b0;
            complete_play_d = 1'b1;
          end else if (OFF_CYCLES != 0) begin
            state_d        = ST_OFF;
            colour_out_d   = 2'b00;
            colour_valid_d = 1'b0;
            tmr_load       = 1'b1;
            tmr_val        = OFF_LOAD;
          end else begin
            play_index_d = play_index_q + LEN_W'(1);
            colour_out_d = colour_at(seq_q, play_index_q + LEN_W'(1));
            tmr_load     = 1'b1;
            tmr_val      = ON_LOAD;
          end
        end
      end

      ST_OFF: begin
        if (!en) begin
          state_d        = ST_IDLE;
          colour_out_d   = 2'b00;
          colour_valid_d = 1'b0;
          play_index_d   = '0;
        end else if (tmr_tc) begin
          state_d        = ST_ON;
          play_index_d   = play_index_q + LEN_W'(1);
          colour_valid_d = 1'b1;
          colour_out_d   = colour_at(seq_q, play_index_q + LEN_W'(1));
          tmr_load       = 1'b1;
          tmr_val        = ON_LOAD;
        end
      end

      default: begin
        colour_out_d   = 2'b00;
        colour_valid_d = 1'b0;
        if (!en) begin
          state_d         = ST_IDLE;
          play_index_d    = '0;
          complete_play_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      colour_out_q    <= 2'b00;
      colour_valid_q  <= 1'b0;
      play_index_q    <= '0;
      complete_play_q <= 1'b0;
      seq_q           <= '0;
      len_q           <= '0;
      en_low_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      colour_out_q    <= colour_out_d;
      colour_valid_q  <= colour_valid_d;
      play_index_q    <= play_index_d;
      complete_play_q <= complete_play_d;
      seq_q           <= seq_d;
      len_q           <= len_d;
      en_low_q        <= en_low_d;
    end
  end

  assign colour_out    = colour_out_q;
  assign colour_valid  = colour_valid_q;
  assign play_index    = play_index_q;
  assign complete_play = complete_play_q;

endmodule

// File: tb/tb_sequence_player.sv
// Randomised bench for sequence_player: two instances (with and without a gap)
// checked cycle by cycle against a timeline model derived from the playback rules.
module tb_sequence_player;

  localparam int ON_A = 3, OFF_A = 2;
  localparam int ON_B = 3, OFF_B = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        en_a, en_b;
  logic [31:0] seq_a, seq_b;
  logic [3:0]  len_a, len_b;
  logic [1:0]  col_a, col_b;
  logic        val_a, val_b, cp_a, cp_b;
  logic [3:0]  idx_a, idx_b;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       valid;
    logic [1:0] colour;
    logic [3:0] idx;
    logic       done;
  } exp_t;

  sequence_player #(.ON_CYCLES(ON_A), .OFF_CYCLES(OFF_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .sequence_val(seq_a), .sequence_len(len_a),
    .colour_out(col_a), .colour_valid(val_a), .play_index(idx_a), .complete_play(cp_a)
  );

  sequence_player #(.ON_CYCLES(ON_B), .OFF_CYCLES(OFF_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .sequence_val(seq_b), .sequence_len(len_b),
    .colour_out(col_b), .colour_valid(val_b), .play_index(idx_b), .complete_play(cp_b)
  );

  // Expected outputs t cycles after the start edge (t=0: still idle). Each colour
  // occupies a slot of on+off cycles; the gap of the last slot is never played.
  function automatic exp_t model(input logic [31:0] seq, input int len, input int on,
                                 input int off, input int t);
    exp_t e;
    int total, u, i;
    e = '0;
    if (t <= 0) return e;
    if (len == 0) begin
      e.done = 1'b1;
      return e;
    end
    total = len * on + (len - 1) * off;
    if (t > total) begin
      e.done = 1'b1;
      e.idx  = 4'(len - 1);
      return e;
    end
    u = t - 1;
    i = u / (on + off);
    e.idx = 4'(i);
    if ((u % (on + off)) < on) begin
      e.valid  = 1'b1;
      e.colour = seq[2*i +: 2];
    end
    return e;
  endfunction

  task automatic test_reset();
    exp_t got;
    rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0;
    seq_a = '0; seq_b = '0; len_a = '0; len_b = '0;
    repeat (3) @(negedge clk);
    got = {val_a, col_a, idx_a, cp_a};
    checks++;
    if (got !== exp_t'(0)) begin
      errors++;
      $display("FAIL reset_a got=%b exp=%b", got, exp_t'(0));
    end
    got = {val_b, col_b, idx_b, cp_b};
    checks++;
    if (got !== exp_t'(0)) begin
      errors++;
      $display("FAIL reset_b got=%b exp=%b", got, exp_t'(0));
    end
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset: outputs cleared");
  endtask

  task automatic test_basic();
    exp_t got, e;
    seq_a = 32'h0000_00E4; len_a = 4'd4; en_a = 1'b1;
    for (int t = 1; t <= 22; t++) begin
      @(negedge clk);
      got = {val_a, col_a, idx_a, cp_a};
      e = model(32'h0000_00E4, 4, ON_A, OFF_A, t);
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL basic t=%0d got=%b exp=%b", t, got, e);
      end
    end
    en_a = 1'b0;
    @(negedge clk);
    got = {val_a, col_a, idx_a, cp_a};
    checks++;
    if (got !== exp_t'(0)) begin
      errors++;
      $display("FAIL basic_release got=%b exp=%b", got, exp_t'(0));
    end
    $display("basic: seq=E4 len=4 played");
  endtask

  task automatic test_len_zero();
    exp_t got, e;
    logic [31:0] s;
    s = $urandom;
    seq_a = s; len_a = 4'd0; en_a = 1'b1;
    for (int t = 1; t <= 5; t++) begin
      @(negedge clk);
      got = {val_a, col_a, idx_a, cp_a};
      e = model(s, 0, ON_A, OFF_A, t);
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL len_zero t=%0d got=%b exp=%b", t, got, e);
      end
    end
    en_a = 1'b0;
    @(negedge clk);
    $display("len_zero: seq=%h completes immediately", s);
  endtask

  task automatic test_full_len();
    exp_t got, e;
    int n_valid, max_idx;
    n_valid = 0; max_idx = 0;
    seq_b = 32'hFFFF_FFFF; len_b = 4'd15; en_b = 1'b1;
    for (int t = 1; t <= 48; t++) begin
      @(negedge clk);
      got = {val_b, col_b, idx_b, cp_b};
      e = model(32'hFFFF_FFFF, 15, ON_B, OFF_B, t);
      if (val_b === 1'b1) n_valid++;
      if (int'(idx_b) > max_idx) max_idx = int'(idx_b);
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL full_len t=%0d got=%b exp=%b", t, got, e);
      end
    end
    checks++;
    if (n_valid != 45 || max_idx != 14) begin
      errors++;
      $display("FAIL full_len_totals valid_cycles=%0d exp=45 max_index=%0d exp=14", n_valid, max_idx);
    end
    en_b = 1'b0;
    @(negedge clk);
    $display("full_len: 15 colours back-to-back, valid cycles=%0d", n_valid);
  endtask

  task automatic test_abort();
    exp_t got, e;
    logic [31:0] s;
    s = $urandom;
    seq_a = s; len_a = 4'd4; en_a = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      @(negedge clk);
      got = {val_a, col_a, idx_a, cp_a};
      e = model(s, 4, ON_A, OFF_A, t);
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL abort_pre t=%0d got=%b exp=%b", t, got, e);
      end
    end
    en_a = 1'b0;
    @(negedge clk);
    got = {val_a, col_a, idx_a, cp_a};
    checks++;
    if (got !== exp_t'(0)) begin
      errors++;
      $display("FAIL abort_idle got=%b exp=%b", got, exp_t'(0));
    end
    en_a = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      @(negedge clk);
      got = {val_a, col_a, idx_a, cp_a};
      e = model(s, 4, ON_A, OFF_A, t);
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL abort_restart t=%0d got=%b exp=%b", t, got, e);
      end
    end
    en_a = 1'b0;
    @(negedge clk);
    $display("abort: seq=%h aborted in colour 2 then replayed", s);
  endtask

  task automatic test_input_change();
    exp_t got, e;
    logic [31:0] s;
    int l, total;
    s = $urandom;
    l = $urandom_range(3, 8);
    total = l * ON_A + (l - 1) * OFF_A;
    seq_a = s; len_a = 4'(l); en_a = 1'b1;
    for (int t = 1; t <= total + 2; t++) begin
      @(negedge clk);
      got = {val_a, col_a, idx_a, cp_a};
      e = model(s, l, ON_A, OFF_A, t);
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL input_change t=%0d got=%b exp=%b", t, got, e);
      end
      seq_a = ~s ^ $urandom;
      len_a = 4'($urandom_range(0, 15));
    end
    en_a = 1'b0;
    @(negedge clk);
    $display("input_change: seq=%h len=%0d held despite input churn", s, l);
  endtask

  task automatic test_reset_mid_play();
    exp_t got, e;
    logic [31:0] s;
    s = $urandom;
    seq_a = s; len_a = 4'd4; en_a = 1'b1;
    for (int t = 1; t <= 4; t++) @(negedge clk);
    got = {val_a, col_a, idx_a, cp_a};
    e = model(s, 4, ON_A, OFF_A, 4);
    checks++;
    if (got !== e || e.valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_in_gap got=%b exp=%b", got, e);
    end
    rst_n = 1'b0;
    @(negedge clk);
    got = {val_a, col_a, idx_a, cp_a};
    checks++;
    if (got !== exp_t'(0)) begin
      errors++;
      $display("FAIL rst_mid_cleared got=%b exp=%b", got, exp_t'(0));
    end
    rst_n = 1'b1;
    for (int t = 1; t <= 5; t++) begin
      @(negedge clk);
      got = {val_a, col_a, idx_a, cp_a};
      checks++;
      if (got !== exp_t'(0)) begin
        errors++;
        $display("FAIL rst_no_autostart t=%0d got=%b exp=%b", t, got, exp_t'(0));
      end
    end
    en_a = 1'b0;
    @(negedge clk);
    en_a = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      @(negedge clk);
      got = {val_a, col_a, idx_a, cp_a};
      e = model(s, 4, ON_A, OFF_A, t);
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL rst_restart t=%0d got=%b exp=%b", t, got, e);
      end
    end
    en_a = 1'b0;
    @(negedge clk);
    $display("reset_mid_play: seq=%h cleared, restarted after en toggle", s);
  endtask

  task automatic test_random();
    exp_t got, e;
    logic [31:0] sa, sb;
    int la, lb, ta, tb, tmax;
    for (int n = 0; n < 6; n++) begin
      sa = $urandom; sb = $urandom;
      la = $urandom_range(0, 15); lb = $urandom_range(0, 15);
      ta = (la == 0) ? 0 : la * ON_A + (la - 1) * OFF_A;
      tb = (lb == 0) ? 0 : lb * ON_B + (lb - 1) * OFF_B;
      tmax = ((ta > tb) ? ta : tb) + 3;
      seq_a = sa; len_a = 4'(la); en_a = 1'b1;
      seq_b = sb; len_b = 4'(lb); en_b = 1'b1;
      for (int t = 1; t <= tmax; t++) begin
        @(negedge clk);
        got = {val_a, col_a, idx_a, cp_a};
        e = model(sa, la, ON_A, OFF_A, t);
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL random_a n=%0d t=%0d got=%b exp=%b", n, t, got, e);
        end
        got = {val_b, col_b, idx_b, cp_b};
        e = model(sb, lb, ON_B, OFF_B, t);
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL random_b n=%0d t=%0d got=%b exp=%b", n, t, got, e);
        end
      end
      en_a = 1'b0; en_b = 1'b0;
      @(negedge clk);
      $display("random %0d: a seq=%h len=%0d, b seq=%h len=%0d", n, sa, la, sb, lb);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len_zero();
    test_full_len();
    test_abort();
    test_input_change();
    test_reset_mid_play();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
